// File: rtl/uart_pkg.sv
// Shared UART frame definitions for the transmitter and the receiver.
// One start bit, eight data bits sent MSB first, one stop bit.
package uart_pkg;

    localparam int   UART_DATA_BITS   = 8;
    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled.
// o_expire is high for the single cycle that ends each bit period.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_r;

    assign o_expire = i_enable && (count_r == LAST);

    // Period counter; the wrap on expiry is the clear at every bit transition.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_r <= {CW{1'b0}};
        end else if (i_clear) begin
            count_r <= {CW{1'b0}};
        end else if (i_enable) begin
            if (count_r == LAST) begin
                count_r <= {CW{1'b0}};
            end else begin
                count_r <= count_r + CW'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/uart_txr.sv
// UART transmitter: serialises a byte as start, 8 data bits MSB first, stop.
// All outputs are registered; bit timing comes from uart_bit_timer.
module uart_txr
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_line,
    output logic       o_tx_busy,
    output logic       o_tx_done
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_t state_r;
    logic [7:0]  shift_r;
    logic [2:0]  bit_cnt_r;
    logic        tx_line_r;
    logic        tx_busy_r;
    logic        tx_done_r;
    logic        timer_clear_s;
    logic        timer_expire_s;

    // Holding the timer cleared in IDLE makes every frame start from count 0.
    assign timer_clear_s = (state_r == IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (timer_clear_s),
        .i_enable (!timer_clear_s),
        .o_expire (timer_expire_s)
    );

    // Frame sequencer; the line always presents shift_r[7] for data bits.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r   <= IDLE;
            shift_r   <= 8'h00;
            bit_cnt_r <= 3'd0;
            tx_line_r <= UART_IDLE_LEVEL;
            tx_busy_r <= 1'b0;
            tx_done_r <= 1'b0;
        end else begin
            tx_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    tx_line_r <= UART_IDLE_LEVEL;
                    tx_busy_r <= 1'b0;
                    bit_cnt_r <= 3'd0;
                    if (i_tx_start) begin
                        shift_r   <= i_tx_byte;
                        tx_line_r <= UART_START_LEVEL;
                        tx_busy_r <= 1'b1;
                        state_r   <= START;
                    end
                end
                START: begin
                    if (timer_expire_s) begin
                        tx_line_r <= shift_r[7];
                        shift_r   <= {shift_r[6:0], 1'b0};
                        bit_cnt_r <= 3'd0;
                        state_r   <= DATA;
                    end
                end
                DATA: begin
                    if (timer_expire_s) begin
                        if (bit_cnt_r == LAST_BIT) begin
                            tx_line_r <= UART_IDLE_LEVEL;
                            state_r   <= STOP;
                        end else begin
                            tx_line_r <= shift_r[7];
                            shift_r   <= {shift_r[6:0], 1'b0};
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (timer_expire_s) begin
                        tx_busy_r <= 1'b0;
                        tx_done_r <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    shift_r   <= 8'h00;
                    bit_cnt_r <= 3'd0;
                    tx_line_r <= UART_IDLE_LEVEL;
                    tx_busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx_line = tx_line_r;
    assign o_tx_busy = tx_busy_r;
    assign o_tx_done = tx_done_r;

endmodule
